// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: constants shared by the peripheral bus and its timer.
//   PERIPH_BASE : address nibble addr[31:28] that selects this block
//   reg_sel_e   : word offsets (addr[4:2]) of the register map
//   TCON_*      : bit positions inside the timer control register
package periph_bus_pkg;

  localparam logic [3:0] PERIPH_BASE = 4'h4;

  typedef enum logic [2:0] {
    REG_TH       = 3'd0,
    REG_TL       = 3'd1,
    REG_TCON     = 3'd2,
    REG_LED      = 3'd3,
    REG_SWITCH   = 3'd4,
    REG_DIGI     = 3'd5,
    REG_SYSTICK  = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_sel_e;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:28] == PERIPH_BASE;
  endfunction

endpackage

// File: rtl/periph_bus_if.sv
// periph_bus_if: CPU-side memory-mapped bus.
//   rd, wr : read / write strobes (master -> slave)
//   addr   : byte address, word aligned
//   wdata  : write data
//   rdata  : combinational read data (slave -> master)
interface periph_bus_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/periph_timer.sv
// periph_timer: reloading 32-bit up-counter with sticky interrupt status.
//   clk, reset            : clock, asynchronous active-low reset
//   wr_th/wr_tl/wr_tcon   : decoded CPU write strobes
//   wdata                 : CPU write data
//   th, tl, tcon          : register values for readback
//   irqout                : interrupt request (registered TCON status bit)
module periph_timer
  import periph_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irqout
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (wr_th) th_d = wdata;

    // A CPU write to TL or TCON cancels the whole timer step for that
    // cycle (increment, reload and status set), so software always sees
    // exactly what it wrote.
    if (wr_tl || wr_tcon) begin
      if (wr_tl)   tl_d   = wdata;
      if (wr_tcon) tcon_d = wdata[2:0];
    end else if (tcon_q[TCON_EN]) begin
      if (tl_q == '1) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = tcon_q;
  assign irqout = tcon_q[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// periph_bus: memory-mapped peripheral block at 0x4xxx_xxxx.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : CPU bus (slave side), combinational rdata
//   switch     : board switch inputs (readable at offset 0x10)
//   led        : LED register output
//   digi       : 7-segment drive, [11:8] digit select, [7:0] segments
//   irqout     : timer interrupt request
module periph_bus
  import periph_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  periph_bus_if.slave bus,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  logic        hit;
  reg_sel_e    sel;
  logic        wr_en;

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;

  logic [31:0] th, tl;
  logic [2:0]  tcon;

  // addr[27:5] alias freely and addr[1:0] is assumed zero.
  logic unused_addr;
  assign unused_addr = ^{bus.addr[27:5], bus.addr[1:0]};

  assign hit   = is_periph(bus.addr);
  assign sel   = reg_sel_e'(bus.addr[4:2]);
  assign wr_en = bus.wr && hit;

  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_en && (sel == REG_TH)),
    .wr_tl   (wr_en && (sel == REG_TL)),
    .wr_tcon (wr_en && (sel == REG_TCON)),
    .wdata   (bus.wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irqout  (irqout)
  );

  always_comb begin
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;
    if (wr_en) begin
      case (sel)
        REG_LED:     led_d     = bus.wdata[7:0];
        REG_DIGI:    digi_d    = bus.wdata[11:0];
        REG_SYSTICK: systick_d = bus.wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd && hit) begin
      case (sel)
        REG_TH:      bus.rdata = th;
        REG_TL:      bus.rdata = tl;
        REG_TCON:    bus.rdata = {29'd0, tcon};
        REG_LED:     bus.rdata = {24'd0, led_q};
        REG_SWITCH:  bus.rdata = {24'd0, switch};
        REG_DIGI:    bus.rdata = {20'd0, digi_q};
        REG_SYSTICK: bus.rdata = systick_q;
        default:     bus.rdata = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_periph_bus.sv
module tb_periph_bus;

  logic        clk;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  periph_bus_if bus_if ();

  periph_bus dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one write for exactly one rising edge; returns 1ns after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.wr    = 1'b0;
  endtask

  // Combinational read, 1ns long.
  task automatic bus_peek(input logic [31:0] a, output logic [31:0] v);
    bus_if.wr   = 1'b0;
    bus_if.rd   = 1'b1;
    bus_if.addr = a;
    #1;
    v = bus_if.rdata;
    bus_if.rd   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp;
    logic [31:0] a;
    reset  = 1'b0;
    switch = 8'hA5;
    #12;
    for (int unsigned i = 0; i < 8; i++) begin
      a = 32'h4000_0000 + (i << 2);
      exp = (i == 4) ? 32'h0000_00A5 : 32'h0;
      bus_peek(a, v);
      checks++;
      if (v !== exp) begin
        $display("FAIL reset_read[%0d] got=%h exp=%h", i, v, exp);
        errors++;
      end
    end
    checks++;
    if (led !== 8'h00) begin $display("FAIL reset_led got=%h exp=00", led); errors++; end
    checks++;
    if (digi !== 12'h000) begin $display("FAIL reset_digi got=%h exp=000", digi); errors++; end
    checks++;
    if (irqout !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", irqout); errors++; end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_timer_reload();
    logic [31:0] v;
    bus_write(32'h4000_0000, 32'hFFFF_FFF0);
    bus_write(32'h4000_0004, 32'hFFFF_FFFE);
    bus_write(32'h4000_0008, 32'h0000_0003);
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin $display("FAIL tl_after_tcon_write got=%h exp=fffffffe", v); errors++; end
    bus_peek(32'h4000_0000, v);
    checks++;
    if (v !== 32'hFFFF_FFF0) begin $display("FAIL th_readback got=%h exp=fffffff0", v); errors++; end
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin $display("FAIL tl_max got=%h exp=ffffffff", v); errors++; end
    checks++;
    if (irqout !== 1'b0) begin $display("FAIL irq_before_reload got=%b exp=0", irqout); errors++; end
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'hFFFF_FFF0) begin $display("FAIL tl_reload got=%h exp=fffffff0", v); errors++; end
    bus_peek(32'h4000_0008, v);
    checks++;
    if (v !== 32'h0000_0007) begin $display("FAIL tcon_status got=%h exp=00000007", v); errors++; end
    checks++;
    if (irqout !== 1'b1) begin $display("FAIL irq_set got=%b exp=1", irqout); errors++; end
  endtask

  task automatic test_irq_clear();
    logic [31:0] v;
    bus_write(32'h4000_0008, 32'h0000_0001);
    checks++;
    if (irqout !== 1'b0) begin $display("FAIL irq_clear got=%b exp=0", irqout); errors++; end
    bus_peek(32'h4000_0008, v);
    checks++;
    if (v !== 32'h0000_0001) begin $display("FAIL tcon_after_clear got=%h exp=00000001", v); errors++; end
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'hFFFF_FFF1) begin $display("FAIL tl_continues got=%h exp=fffffff1", v); errors++; end
  endtask

  task automatic test_write_collision();
    logic [31:0] v;
    bus_write(32'h4000_0008, 32'h0000_0003);
    bus_write(32'h4000_0004, 32'hFFFF_FFFF);
    // This edge would reload TL and set status; the CPU write must win.
    bus_write(32'h4000_0004, 32'h0000_1234);
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0000_1234) begin $display("FAIL tl_write_wins got=%h exp=00001234", v); errors++; end
    bus_peek(32'h4000_0008, v);
    checks++;
    if (v !== 32'h0000_0003) begin $display("FAIL tcon_no_status got=%h exp=00000003", v); errors++; end
    checks++;
    if (irqout !== 1'b0) begin $display("FAIL irq_no_status got=%b exp=0", irqout); errors++; end
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0000_1235) begin $display("FAIL tl_after_collision got=%h exp=00001235", v); errors++; end
  endtask

  task automatic test_map();
    logic [31:0] v;
    bus_write(32'h4000_000C, 32'hFFFF_FF3C);
    bus_write(32'h4000_0014, 32'hFFFF_FABC);
    checks++;
    if (led !== 8'h3C) begin $display("FAIL led_write got=%h exp=3c", led); errors++; end
    checks++;
    if (digi !== 12'hABC) begin $display("FAIL digi_write got=%h exp=abc", digi); errors++; end
    bus_peek(32'h4ABC_DE14, v);
    checks++;
    if (v !== 32'h0000_0ABC) begin $display("FAIL digi_alias_read got=%h exp=00000abc", v); errors++; end
    bus_write(32'h1000_000C, 32'h0000_00FF);
    checks++;
    if (led !== 8'h3C) begin $display("FAIL led_offbase got=%h exp=3c", led); errors++; end
    bus_write(32'h4000_001C, 32'hDEAD_BEEF);
    bus_peek(32'h4000_001C, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL unmapped_read got=%h exp=00000000", v); errors++; end
    bus_write(32'h4000_0010, 32'h0000_0000);
    bus_peek(32'h4000_0010, v);
    checks++;
    if (v !== 32'h0000_00A5) begin $display("FAIL switch_read got=%h exp=000000a5", v); errors++; end
    bus_if.rd   = 1'b0;
    bus_if.addr = 32'h4000_000C;
    #1;
    checks++;
    if (bus_if.rdata !== 32'h0) begin $display("FAIL rd_low got=%h exp=00000000", bus_if.rdata); errors++; end
    bus_write(32'h4000_0018, 32'hFFFF_FFFE);
    bus_peek(32'h4000_0018, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin $display("FAIL systick_load got=%h exp=fffffffe", v); errors++; end
    step();
    step();
    bus_peek(32'h4000_0018, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL systick_wrap got=%h exp=00000000", v); errors++; end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    bus_write(32'h4000_0004, 32'h0000_0100);
    bus_write(32'h4000_0008, 32'h0000_0005);
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0000_0100) begin $display("FAIL tl_before_reset got=%h exp=00000100", v); errors++; end
    checks++;
    if (irqout !== 1'b1) begin $display("FAIL irq_before_reset got=%b exp=1", irqout); errors++; end
    #1;
    reset = 1'b0;
    #1;
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL tl_in_reset got=%h exp=00000000", v); errors++; end
    checks++;
    if (irqout !== 1'b0) begin $display("FAIL irq_in_reset got=%b exp=0", irqout); errors++; end
    checks++;
    if (led !== 8'h00) begin $display("FAIL led_in_reset got=%h exp=00", led); errors++; end
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL tl_held_after_reset got=%h exp=00000000", v); errors++; end
    bus_write(32'h4000_0008, 32'h0000_0001);
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL tl_on_enable_edge got=%h exp=00000000", v); errors++; end
    step();
    bus_peek(32'h4000_0004, v);
    checks++;
    if (v !== 32'h0000_0001) begin $display("FAIL tl_resume got=%h exp=00000001", v); errors++; end
  endtask

  initial begin
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    test_reset();
    test_timer_reload();
    test_irq_clear();
    test_write_collision();
    test_map();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
